// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 size codes, FSM
// state encoding and big-endian lane-select helpers.
package lsu_pkg;

  localparam int LSU_DATA_W = 32;

  // RV32 funct3 size/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Right-aligned lane masks, shifted into place by the helpers below
  localparam logic [LSU_DATA_W-1:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [LSU_DATA_W-1:0] HALF_MASK = 32'h0000_FFFF;

  // Big-endian: byte offset 0 is the most significant lane (shift 24)
  function automatic logic [4:0] byteShift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  // Big-endian: addr[1]=0 selects the upper halfword (shift 16)
  function automatic logic [4:0] halfShift(input logic hiSel);
    return {~hiSel, 4'b0000};
  endfunction

  // Stores accept only SB/SH/SW; loads reject codes 3, 6 and 7
  function automatic logic isInvalidF3(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 > F3_W);
    end
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: extracts and extends the
// loaded byte/halfword/word and merges sub-word store data into a read word.
// Halfwords look only at offset[1]; words ignore the offset entirely.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] i_word,
  input  logic [1:0]            i_offset,
  input  logic [2:0]            i_funct3,
  input  logic [LSU_DATA_W-1:0] i_wdata,
  output logic [LSU_DATA_W-1:0] o_load_data,
  output logic [LSU_DATA_W-1:0] o_store_data
);

  logic [4:0]            w_byteShift;
  logic [4:0]            w_halfShift;
  logic [LSU_DATA_W-1:0] w_byteWord;
  logic [LSU_DATA_W-1:0] w_halfWord;
  logic [LSU_DATA_W-1:0] w_byteLaneMask;
  logic [LSU_DATA_W-1:0] w_halfLaneMask;

  assign w_byteShift    = byteShift(i_offset);
  assign w_halfShift    = halfShift(i_offset[1]);
  assign w_byteWord     = i_word >> w_byteShift;
  assign w_halfWord     = i_word >> w_halfShift;
  assign w_byteLaneMask = BYTE_MASK << w_byteShift;
  assign w_halfLaneMask = HALF_MASK << w_halfShift;

  // Load extraction: pick the lane then sign- or zero-extend by funct3
  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byteWord[7]}}, w_byteWord[7:0]};
      F3_BU:   o_load_data = {24'd0, w_byteWord[7:0]};
      F3_H:    o_load_data = {{16{w_halfWord[15]}}, w_halfWord[15:0]};
      F3_HU:   o_load_data = {16'd0, w_halfWord[15:0]};
      F3_W:    o_load_data = i_word;
      default: o_load_data = '0;
    endcase
  end

  // Store merge: replace only the addressed lane, keep every other byte
  always_comb begin
    o_store_data = i_word;
    case (i_funct3)
      F3_B:    o_store_data = (i_word & ~w_byteLaneMask) |
                              ((i_wdata & BYTE_MASK) << w_byteShift);
      F3_H:    o_store_data = (i_word & ~w_halfLaneMask) |
                              ((i_wdata & HALF_MASK) << w_halfShift);
      F3_W:    o_store_data = i_wdata;
      default: o_store_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences core load/store requests onto a word-wide,
// big-endian, byte-addressed data memory with combinational read and
// posedge write. Sub-word stores are done as read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses return an error instead of silently dropping the low address bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

  // The lane logic is written for a 32-bit bus only
  generate
    if (DATA_BUS_WIDTH != LSU_DATA_W) begin : g_bad_width
      $error("load_store_unit: DATA_BUS_WIDTH must be 32");
    end
  endgenerate

  lsu_state_t                r_state;
  logic                      r_we;
  logic [2:0]                r_funct3;
  logic [ADDR_BUS_WIDTH-1:0] r_addr;
  logic [DATA_BUS_WIDTH-1:0] r_word;
  logic                      r_reqReady;
  logic                      r_respValid;
  logic [DATA_BUS_WIDTH-1:0] r_respRdata;
  logic                      r_respErr;

  logic [ADDR_BUS_WIDTH-1:0] w_alignedAddr;
  logic [DATA_BUS_WIDTH-1:0] w_loadData;
  logic [DATA_BUS_WIDTH-1:0] w_storeData;
  logic                      w_invalid;
  logic                      w_misaligned;
  logic                      w_memActive;

  assign w_alignedAddr = {r_addr[ADDR_BUS_WIDTH-1:2], 2'b00};
  assign w_invalid     = isInvalidF3(req_we, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // r_word carries store data into READ and the merged word out of it
  lsu_align u_align (
    .i_word       (mem_read_data),
    .i_offset     (r_addr[1:0]),
    .i_funct3     (r_funct3),
    .i_wdata      (r_word),
    .o_load_data  (w_loadData),
    .o_store_data (w_storeData)
  );

  // Memory side is decoded from state so reset kills a pending write at once
  assign w_memActive    = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign mem_addr       = w_memActive ? w_alignedAddr : '0;
  assign mem_write_en   = (r_state == ST_WRITE);
  assign mem_write_data = mem_write_en ? r_word : '0;

  assign req_ready  = r_reqReady;
  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;

  // Request sequencing FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_word      <= '0;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_respRdata <= '0;
      r_respErr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_reqReady) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_word      <= req_wdata;
            r_reqReady  <= 1'b0;
            r_respRdata <= '0;
            if (w_invalid || w_misaligned) begin
              r_state     <= ST_RESP;
              r_respValid <= 1'b1;
              r_respErr   <= 1'b1;
            end else if (req_we && (req_funct3 == F3_W)) begin
              r_state   <= ST_WRITE;
              r_respErr <= 1'b0;
            end else begin
              r_state   <= ST_READ;
              r_respErr <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (r_we) begin
            r_word  <= w_storeData;
            r_state <= ST_WRITE;
          end else begin
            r_respRdata <= w_loadData;
            r_respErr   <= 1'b0;
            r_respValid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          r_respRdata <= '0;
          r_respErr   <= 1'b0;
          r_respValid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_respValid <= 1'b0;
            r_reqReady  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_reqReady  <= 1'b1;
          r_respValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural big-endian word
// memory. Latency is counted in clock edges starting with the accept edge.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic [31:0] mem_read_data;

  logic [31:0] tbMem [0:63];
  logic        preload;
  int          wrPulses;
  int          vectors;
  int          miscompares;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          pulses;
  } expT;

  expT sbQ[$];

  load_store_unit #(
    .ADDR_BUS_WIDTH (32),
    .DATA_BUS_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = tbMem[mem_addr[7:2]];

  // Behavioural memory: preload image while preload is high, else whole-word writes
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) tbMem[i] <= 32'h0;
      tbMem[4]  <= 32'h807F_1234;
      tbMem[8]  <= 32'h1122_3344;
      tbMem[9]  <= 32'h1122_3344;
      tbMem[10] <= 32'h1122_3344;
    end else if (mem_write_en) begin
      tbMem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  // Count write strobes, sampled mid-cycle
  initial wrPulses = 0;
  always @(negedge clk) begin
    if (mem_write_en) wrPulses = wrPulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr,
                               input int expLat, input int expPulses, input int holdCycles);
    expT         e;
    int          cycles;
    int          p0;
    logic [31:0] heldData;
    @(negedge clk);
    checkOutput({name, "/req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.rdata  = expRdata;
    e.err    = expErr;
    e.lat    = expLat;
    e.pulses = expPulses;
    sbQ.push_back(e);
    p0 = wrPulses;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    cycles = 1;
    while (!resp_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!resp_valid) begin
      checkOutput({name, "/resp_timeout"}, 32'd0, 32'd1);
      void'(sbQ.pop_front());
      return;
    end
    heldData = resp_rdata;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({name, "/hold_valid"}, {31'd0, resp_valid}, 32'd1);
      checkOutput({name, "/hold_rdata"}, resp_rdata, heldData);
      checkOutput({name, "/hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    e = sbQ.pop_front();
    checkOutput({name, "/rdata"}, resp_rdata, e.rdata);
    checkOutput({name, "/err"}, {31'd0, resp_err}, {31'd0, e.err});
    checkOutput({name, "/latency"}, 32'(cycles), 32'(e.lat));
    checkOutput({name, "/write_pulses"}, 32'(wrPulses - p0), 32'(e.pulses));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput({name, "/valid_cleared"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int sawResp;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    preload     = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    resp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset/req_ready",  {31'd0, req_ready},    32'd1);
    checkOutput("reset/resp_valid", {31'd0, resp_valid},   32'd0);
    checkOutput("reset/resp_err",   {31'd0, resp_err},     32'd0);
    checkOutput("reset/resp_rdata", resp_rdata,            32'd0);
    checkOutput("reset/mem_we",     {31'd0, mem_write_en}, 32'd0);
    checkOutput("reset/mem_addr",   mem_addr,              32'd0);
    checkOutput("reset/mem_wdata",  mem_write_data,        32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    preload = 1'b0;

    // Loads from word 0x10 = 0x807F1234
    applyStimulus("LB_10",  1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 0);
    applyStimulus("LBU_10", 1'b0, 3'd4, 32'h10, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 0);
    applyStimulus("LB_11",  1'b0, 3'd0, 32'h11, 32'h0, 32'h0000_007F, 1'b0, 2, 0, 0);
    applyStimulus("LH_12",  1'b0, 3'd1, 32'h12, 32'h0, 32'h0000_1234, 1'b0, 2, 0, 0);
    applyStimulus("LH_10",  1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFF_807F, 1'b0, 2, 0, 0);
    applyStimulus("LHU_10", 1'b0, 3'd5, 32'h10, 32'h0, 32'h0000_807F, 1'b0, 2, 0, 0);
    applyStimulus("LBU_13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h0000_0034, 1'b0, 2, 0, 0);

    // Sub-word stores via read-modify-write
    applyStimulus("SB_23", 1'b1, 3'd0, 32'h23, 32'hAABB_CCDD, 32'h0, 1'b0, 3, 1, 0);
    checkOutput("SB_23/mem", tbMem[8], 32'h1122_33DD);
    applyStimulus("SH_24", 1'b1, 3'd1, 32'h24, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 0);
    checkOutput("SH_24/mem", tbMem[9], 32'hBEEF_3344);

    // Word store then read back
    applyStimulus("SW_14", 1'b1, 3'd2, 32'h14, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1, 0);
    checkOutput("SW_14/mem", tbMem[5], 32'hCAFE_F00D);
    applyStimulus("LW_14", 1'b0, 3'd2, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0, 0);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus("LW_12", 1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
    applyStimulus("LW_12", 1'b0, 3'd2, 32'h12, 32'h0, 32'h807F_1234, 1'b0, 2, 0, 0);
`endif

    // Response back-pressure for five cycles
    applyStimulus("LW_hold", 1'b0, 3'd2, 32'h10, 32'h0, 32'h807F_1234, 1'b0, 2, 0, 5);

    // Invalid funct3 codes: no memory access, error response
    applyStimulus("ST_f3_7", 1'b1, 3'd7, 32'h14, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 0, 0);
    checkOutput("ST_f3_7/mem", tbMem[5], 32'hCAFE_F00D);
    applyStimulus("LD_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    applyStimulus("ST_f3_4", 1'b1, 3'd4, 32'h24, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 0);
    checkOutput("ST_f3_4/mem", tbMem[9], 32'hBEEF_3344);

    // Reset during the WRITE cycle of an SB: write must be killed
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h29;
    req_wdata  = 32'h0000_0055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst/we_in_write", {31'd0, mem_write_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst/we_dropped",  {31'd0, mem_write_en}, 32'd0);
    checkOutput("rst/req_ready",   {31'd0, req_ready},    32'd1);
    checkOutput("rst/resp_valid",  {31'd0, resp_valid},   32'd0);
    checkOutput("rst/mem_addr",    mem_addr,              32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst/mem_kept", tbMem[10], 32'h1122_3344);
    @(negedge clk);
    rst_n = 1'b1;
    sawResp = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (resp_valid) sawResp = 1;
    end
    checkOutput("rst/no_response", 32'(sawResp), 32'd0);

    // Unit recovers and the target word is intact
    applyStimulus("LBU_29", 1'b0, 3'd4, 32'h29, 32'h0, 32'h0000_0022, 1'b0, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
